// File: rtl/ro_puf_sequencer_if.sv
// ro_puf_sequencer_if: control, challenge, oscillator and response signals of the RO-PUF sequencer.
// Revision 1.0
`default_nettype none

interface ro_puf_sequencer_if;
  logic       en;
  logic       start;
  logic [7:0] chall_in;
  logic       osc_a;
  logic       osc_b;
  logic [7:0] chall_q;
  logic       scr_load;
  logic       scr_step;
  logic       ro_en;
  logic       busy;
  logic       ready;
  logic [7:0] response;

  modport master (
    output en, start, chall_in, osc_a, osc_b,
    input  chall_q, scr_load, scr_step, ro_en, busy, ready, response
  );

  modport slave (
    input  en, start, chall_in, osc_a, osc_b,
    output chall_q, scr_load, scr_step, ro_en, busy, ready, response
  );
endinterface

`default_nettype wire

// File: rtl/ro_puf_sequencer.sv
// ro_puf_sequencer: races two ring-oscillator groups per bit to build an 8-bit response.
// Revision 1.0
`default_nettype none

module ro_puf_sequencer #(
  parameter int SETTLE = 4,
  parameter int WINDOW = 256,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  ro_puf_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_SETTLE  = 3'd2,
    S_MEASURE = 3'd3,
    S_COMPARE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [15:0]      SETTLE_LAST = 16'(SETTLE - 1);
  localparam logic [15:0]      WINDOW_LAST = 16'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t           state;
  state_t           state_nx;
  logic [15:0]      timer;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic [7:0]       shreg_nx;
  logic [7:0]       chall_q;
  logic [7:0]       response;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;
  logic [2:0]       sync_a;
  logic [2:0]       sync_b;
  logic             accept;
  logic             ro_en;
  logic             scr_load;
  logic             scr_step;
  logic             rise_a;
  logic             rise_b;

  // [1] is the synchronized sample, [2] the previous one for edge detection
  assign rise_a = sync_a[1] & ~sync_a[2];
  assign rise_b = sync_b[1] & ~sync_b[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Strobes and ro_en are gated by en so an abort cycle is quiet
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    ro_en    = 1'b0;
    scr_load = 1'b0;
    scr_step = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (bus.start && bus.en) begin
          state_nx = S_LOAD;
          accept   = 1'b1;
        end else if (!bus.en) begin
          state_nx = S_IDLE;
        end
      end
      S_LOAD: begin
        if (!bus.en) state_nx = S_IDLE;
        else begin
          scr_load = 1'b1;
          state_nx = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (!bus.en) state_nx = S_IDLE;
        else begin
          ro_en = 1'b1;
          if (timer == SETTLE_LAST) state_nx = S_MEASURE;
        end
      end
      S_MEASURE: begin
        if (!bus.en) state_nx = S_IDLE;
        else begin
          ro_en = 1'b1;
          if (timer == WINDOW_LAST) state_nx = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (!bus.en) state_nx = S_IDLE;
        else begin
          scr_step = 1'b1;
          state_nx = (bit_idx == 3'd7) ? S_DONE : S_SETTLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    shreg_nx          = shreg;
    shreg_nx[bit_idx] = (cnt_a > cnt_b);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer    <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      chall_q  <= '0;
      response <= '0;
      cnt_a    <= '0;
      cnt_b    <= '0;
      sync_a   <= '0;
      sync_b   <= '0;
    end else begin
      sync_a <= {sync_a[1:0], bus.osc_a};
      sync_b <= {sync_b[1:0], bus.osc_b};

      if ((state_nx != state) || !((state == S_SETTLE) || (state == S_MEASURE)))
        timer <= '0;
      else
        timer <= timer + 16'd1;

      // Counts survive into COMPARE and are cleared everywhere else
      if (state == S_MEASURE) begin
        if (rise_a && (cnt_a != CNT_MAX)) cnt_a <= cnt_a + 1'b1;
        if (rise_b && (cnt_b != CNT_MAX)) cnt_b <= cnt_b + 1'b1;
      end else if (state != S_COMPARE) begin
        cnt_a <= '0;
        cnt_b <= '0;
      end

      if (accept) begin
        chall_q <= bus.chall_in;
        bit_idx <= '0;
        shreg   <= '0;
      end else if ((state == S_COMPARE) && bus.en) begin
        shreg <= shreg_nx;
        if (bit_idx == 3'd7) response <= shreg_nx;
        else                 bit_idx  <= bit_idx + 3'd1;
      end
    end
  end

  assign bus.chall_q  = chall_q;
  assign bus.scr_load = scr_load;
  assign bus.scr_step = scr_step;
  assign bus.ro_en    = ro_en;
  assign bus.busy     = (state == S_LOAD) || (state == S_SETTLE) ||
                        (state == S_MEASURE) || (state == S_COMPARE);
  assign bus.ready    = (state == S_DONE);
  assign bus.response = response;

endmodule

`default_nettype wire

// File: doc/ro_puf_sequencer.md
RO_PUF_SEQUENCER -- requirements
Module: ro_puf_sequencer

Interface
REQ-001 SHALL have parameter SETTLE, default 4: oscillator settle cycles per bit, 1..255.
REQ-002 SHALL have parameter WINDOW, default 256: measurement cycles per bit, 2..65535.
REQ-003 SHALL have parameter CNT_W, default 16: edge-counter width.
REQ-004 SHALL have port clk, input, 1: single clock for all state.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port en, input, 1: run enable; low aborts any run.
REQ-007 SHALL have port start, input, 1: level-sampled request to begin a response.
REQ-008 SHALL have port chall_in, input, 8: challenge, latched on accepted start.
REQ-009 SHALL have port osc_a, input, 1: lower-group mux output, asynchronous to clk.
REQ-010 SHALL have port osc_b, input, 1: upper-group mux output, asynchronous to clk.
REQ-011 SHALL have port chall_q, output, 8: latched challenge to the scrambler.
REQ-012 SHALL have port scr_load, output, 1: one-cycle scrambler load strobe.
REQ-013 SHALL have port scr_step, output, 1: one-cycle scrambler advance strobe.
REQ-014 SHALL have port ro_en, output, 1: oscillator bank enable.
REQ-015 SHALL have port busy, output, 1: high in every state except IDLE and DONE.
REQ-016 SHALL have port ready, output, 1: high in DONE only.
REQ-017 SHALL have port response, output, 8: completed response word.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, SETTLE, MEASURE, COMPARE, DONE.
REQ-019 IDLE or DONE with start=1 and en=1 SHALL go to LOAD, latch chall_in into chall_q, and clear bit_idx and the shift register.
REQ-020 LOAD SHALL last 1 cycle with scr_load=1, then go to SETTLE.
REQ-021 SETTLE SHALL last SETTLE cycles with ro_en=1 and both edge counters held at 0, then go to MEASURE.
REQ-022 MEASURE SHALL last WINDOW cycles with ro_en=1; each counter increments on every rising edge of its synchronized input.
REQ-023 Each counter SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-024 osc_a and osc_b SHALL each pass a 2-flop synchronizer; a rising edge is synced=1 while the previous synced sample=0.
REQ-025 Edges during LOAD, SETTLE and COMPARE SHALL NOT be counted.
REQ-026 COMPARE SHALL last 1 cycle: ro_en=0, scr_step=1, and bit = (cnt_a > cnt_b), written to shift bit [bit_idx].
REQ-027 A tie (cnt_a == cnt_b) SHALL yield bit 0.
REQ-028 From COMPARE, bit_idx=7 SHALL go to DONE; otherwise bit_idx increments and the FSM goes to SETTLE.
REQ-029 Entering DONE SHALL copy the shift register to response.
REQ-030 DONE SHALL hold ready=1 and response until a new start is accepted.
REQ-031 Latency SHALL be exactly 1 + 8*(SETTLE+WINDOW+1) cycles from the accepting clock edge to ready=1.
REQ-032 start SHALL be ignored while busy=1.
REQ-033 en=0 in any busy state SHALL go to IDLE on the next edge, with ro_en=0, no strobes, and response unchanged.
REQ-034 en=0 in DONE SHALL go to IDLE.
REQ-035 start=1 in DONE with en=1 SHALL restart immediately: ready drops the next cycle, and response holds its old value until the new DONE.
REQ-036 scr_load and scr_step SHALL never be high in the same cycle.

Reset
REQ-037 rst=1 SHALL force IDLE immediately, with ro_en=0, scr_load=0, scr_step=0, busy=0, ready=0, response=0, chall_q=0, counters=0, synchronizers=0 and bit_idx=0.
REQ-038 Reset asserted mid-run SHALL discard partial bits, and no strobe SHALL appear in the first cycle after release.

Verification (SETTLE=2, WINDOW=16)
REQ-039 Start with chall_in=8'hA5; osc_a toggles every 2 clk, osc_b every 4 clk -> scr_load 1 pulse, scr_step 8 pulses, ready at cycle 153, response=8'hFF, chall_q=8'hA5.
REQ-040 Same run with osc_a and osc_b swapped -> response=8'h00; with both identical -> response=8'h00 (tie rule).
REQ-041 Drive osc_a faster only during bits 0, 3 and 7 -> response=8'h89.
REQ-042 Deassert en during bit 4 MEASURE -> IDLE next cycle, ro_en=0, ready=0, and response keeps its previous value.
REQ-043 Assert rst during bit 2 -> all outputs 0 asynchronously; after release, a new start completes normally in 153 cycles.
REQ-044 Pulse start again while busy -> ignored, with exactly 8 scr_step pulses; start held in DONE -> back-to-back run with ready low for 153 cycles.
